// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage with a data-memory request FSM, alignment check and bus timeout.
module memory_stage #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         memRead_E,
    input  logic         memWrite_E,
    input  logic         Branch_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic         zero_E,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    output logic         stall_M,
    output logic         valid_M,
    output logic         PCSrc_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] readData_M,
    output logic [N-1:0] PCBranch_M,
    output logic         exc_M,
    output logic [1:0]   excCode_M
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          memRead_M, memWrite_M, branch_M, zero_M;
    logic [N-1:0]  writeData_M;
    logic          mem_op, misaligned;
    assign mem_op     = valid_E & (memRead_E | memWrite_E);
    assign misaligned = mem_op & (|aluResult_E[2:0]);
    assign stall_M    = state == ACCESS;
    assign dm_req     = state == ACCESS;
    assign dm_we      = (state == ACCESS) & memWrite_M;
    assign dm_addr    = aluResult_M;
    assign dm_wdata   = writeData_M;
    assign PCSrc_M    = valid_M & branch_M & zero_M & ~exc_M;
    // M registers only load in IDLE, so the request channel stays stable for the whole access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            memRead_M   <= 1'b0;
            memWrite_M  <= 1'b0;
            branch_M    <= 1'b0;
            zero_M      <= 1'b0;
            aluResult_M <= '0;
            writeData_M <= '0;
            PCBranch_M  <= '0;
            readData_M  <= '0;
            valid_M     <= 1'b0;
            exc_M       <= 1'b0;
            excCode_M   <= 2'b00;
        end else if (state == IDLE) begin
            memRead_M   <= memRead_E;
            memWrite_M  <= memWrite_E;
            branch_M    <= Branch_E;
            zero_M      <= zero_E;
            aluResult_M <= aluResult_E;
            writeData_M <= writeData_E;
            PCBranch_M  <= PCBranch_E;
            cnt         <= '0;
            state       <= (mem_op & ~misaligned) ? ACCESS : IDLE;
            valid_M     <= valid_E & ~(mem_op & ~misaligned);
            exc_M       <= misaligned;
            excCode_M   <= misaligned ? 2'b01 : 2'b00;
        end else if (dm_ack) begin
            state   <= IDLE;
            valid_M <= 1'b1;
            if (memRead_M & ~memWrite_M) readData_M <= dm_rdata;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
            state     <= IDLE;
            valid_M   <= 1'b1;
            exc_M     <= 1'b1;
            excCode_M <= 2'b10;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized scoreboard bench for memory_stage with a queue-driven memory responder.
module tb_memory_stage;
    localparam int N  = 64;
    localparam int TO = 16;

    logic         clk = 1'b0, reset = 1'b0;
    logic         valid_E = 0, memRead_E = 0, memWrite_E = 0, Branch_E = 0, zero_E = 0;
    logic [N-1:0] aluResult_E = '0, writeData_E = '0, PCBranch_E = '0;
    logic         dm_ack = 1'b0;
    logic [N-1:0] dm_rdata = '0;
    logic         dm_req, dm_we, stall_M, valid_M, PCSrc_M, exc_M;
    logic [N-1:0] dm_addr, dm_wdata, aluResult_M, readData_M, PCBranch_M;
    logic [1:0]   excCode_M;

    memory_stage #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .valid_E(valid_E), .memRead_E(memRead_E),
        .memWrite_E(memWrite_E), .Branch_E(Branch_E), .aluResult_E(aluResult_E),
        .writeData_E(writeData_E), .PCBranch_E(PCBranch_E), .zero_E(zero_E),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .stall_M(stall_M), .valid_M(valid_M),
        .PCSrc_M(PCSrc_M), .aluResult_M(aluResult_M), .readData_M(readData_M),
        .PCBranch_M(PCBranch_M), .exc_M(exc_M), .excCode_M(excCode_M)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] alu, pcb, rd;
        logic         exc;
        logic [1:0]   code;
        logic         pcsrc;
    } exp_t;
    typedef struct {
        logic [N-1:0] addr, wdata, rdata;
        logic         we;
        int           k;
    } mreq_t;

    exp_t         exp_q[$];
    mreq_t        mq[$];
    int           checks = 0, errors = 0;
    logic [N-1:0] last_read = '0;
    logic         rst_test = 1'b0;
    mreq_t        cur;
    int           cyc = 0;

    function automatic logic [N-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference model: decides each operation's outcome from the op kind, alignment and the chosen ack delay
    task automatic issue(input logic v, r, w, br, z, input logic [N-1:0] alu, wd, pcb,
                         input int k, input logic [N-1:0] rdata);
        int   guard = 0;
        exp_t e;
        logic mem, mis;
        @(negedge clk);
        while (stall_M && guard < 100) begin
            valid_E = $urandom; memRead_E = $urandom; memWrite_E = $urandom;
            Branch_E = $urandom; zero_E = $urandom;
            aluResult_E = rnd64(); writeData_E = rnd64(); PCBranch_E = rnd64();
            @(negedge clk);
            guard++;
        end
        if (stall_M) begin
            checks++; errors++;
            $display("FAIL stall_bound: stall_M still %0b after %0d cycles, required 0", stall_M, guard);
        end
        valid_E = v; memRead_E = r; memWrite_E = w; Branch_E = br; zero_E = z;
        aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb;
        mem = r | w;
        mis = mem && (alu[2:0] != 3'b000);
        if (v) begin
            e.alu = alu; e.pcb = pcb; e.exc = 1'b0; e.code = 2'b00;
            if (mis) begin
                e.exc = 1'b1; e.code = 2'b01;
            end else if (mem) begin
                mq.push_back('{addr: alu, wdata: wd, rdata: rdata, we: w, k: k});
                if (k == 0) begin
                    e.exc = 1'b1; e.code = 2'b10;
                end else if (r && !w) last_read = rdata;
            end
            e.rd = last_read;
            e.pcsrc = br && z && !e.exc;
            exp_q.push_back(e);
        end
    endtask

    // Memory responder: acks on the k-th request cycle (k=0 never acks) and checks the request channel
    always @(negedge clk) begin
        if (!reset || rst_test) begin
            dm_ack = 1'b0;
            cyc = 0;
        end else if (dm_req) begin
            if (cyc == 0) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req: dm_req=1 addr=%h, required no request", dm_addr);
                    cur = '{addr: dm_addr, wdata: dm_wdata, rdata: '0, we: dm_we, k: 1};
                end else cur = mq.pop_front();
            end
            checks++;
            if ({dm_addr, dm_wdata, dm_we} !== {cur.addr, cur.wdata, cur.we}) begin
                errors++;
                $display("FAIL req_channel: addr=%h wdata=%h we=%b, required addr=%h wdata=%h we=%b",
                         dm_addr, dm_wdata, dm_we, cur.addr, cur.wdata, cur.we);
            end
            cyc++;
            dm_ack = (cyc == cur.k);
            dm_rdata = (dm_ack && !cur.we) ? cur.rdata : rnd64();
        end else begin
            if (cyc > 0) begin
                checks++;
                if (cyc != ((cur.k == 0) ? TO : cur.k)) begin
                    errors++;
                    $display("FAIL req_len: dm_req lasted %0d cycles, required %0d", cyc, (cur.k == 0) ? TO : cur.k);
                end
            end
            cyc = 0;
            dm_ack = 1'b0;
            dm_rdata = rnd64();
        end
    end

    // Monitor: pops one expectation per valid_M cycle
    always @(negedge clk) begin
        exp_t e;
        if (reset && !rst_test) begin
            checks++;
            if (valid_M) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: valid_M=1 alu=%h, required no result", aluResult_M);
                end else begin
                    e = exp_q.pop_front();
                    if ({aluResult_M, PCBranch_M, readData_M, exc_M, excCode_M, PCSrc_M} !==
                        {e.alu, e.pcb, e.rd, e.exc, e.code, e.pcsrc}) begin
                        errors++;
                        $display("FAIL result: alu=%h pcb=%h rd=%h exc=%b code=%b pcsrc=%b, required alu=%h pcb=%h rd=%h exc=%b code=%b pcsrc=%b",
                                 aluResult_M, PCBranch_M, readData_M, exc_M, excCode_M, PCSrc_M,
                                 e.alu, e.pcb, e.rd, e.exc, e.code, e.pcsrc);
                    end
                end
            end else if (exc_M || excCode_M != 2'b00 || PCSrc_M) begin
                errors++;
                $display("FAIL idle_flags: exc=%b code=%b pcsrc=%b stall=%b, required all 0 while valid_M=0",
                         exc_M, excCode_M, PCSrc_M, stall_M);
            end
        end
    end

    initial begin
        int kind, k, guard;
        logic r, w, v;
        logic [N-1:0] a;
        #3;
        checks++;
        if ({dm_req, dm_we, stall_M, valid_M, PCSrc_M, exc_M, excCode_M, dm_addr, dm_wdata,
             aluResult_M, readData_M, PCBranch_M} !== '0) begin
            errors++;
            $display("FAIL reset_state: req=%b stall=%b valid=%b exc=%b alu=%h rd=%h, required all 0",
                     dm_req, stall_M, valid_M, exc_M, aluResult_M, readData_M);
        end
        @(negedge clk);
        reset = 1'b1;
        issue(1, 0, 0, 0, 0, 64'h10, 64'h0, 64'h0, 0, 64'h0);
        issue(1, 1, 0, 0, 0, 64'h100, 64'h0, 64'h0, 3, 64'hDEADBEEF);
        issue(1, 0, 1, 0, 0, 64'h104, 64'h55, 64'h0, 1, 64'h0);
        issue(1, 1, 0, 0, 0, 64'h200, 64'h0, 64'h0, 0, 64'h0);
        issue(1, 0, 0, 1, 1, 64'h8, 64'h0, 64'h40, 0, 64'h0);
        issue(1, 0, 0, 1, 0, 64'h8, 64'h0, 64'h40, 0, 64'h0);
        issue(1, 1, 0, 1, 1, 64'h208, 64'h0, 64'h44, TO, 64'h1234);
        issue(1, 1, 1, 0, 0, 64'h210, 64'hABCD, 64'h0, 2, 64'h9999);
        issue(1, 0, 1, 0, 0, 64'h218, 64'h77, 64'h0, 1, 64'h0);
        issue(0, 1, 0, 0, 0, 64'h228, 64'h0, 64'h0, 1, 64'h0);
        issue(1, 1, 0, 0, 0, 64'h220, 64'h0, 64'h0, 1, rnd64());
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            r = (kind == 1) || (kind == 3);
            w = (kind == 2) || (kind == 3);
            v = $urandom_range(0, 9) != 0;
            a = rnd64();
            if ($urandom_range(0, 4) != 0) a[2:0] = 3'b000;
            k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
            issue(v, r, w, $urandom, $urandom, a, rnd64(), rnd64(), k, rnd64());
        end
        guard = 0;
        while ((exp_q.size() != 0 || mq.size() != 0 || stall_M) && guard < 300) begin
            issue(0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, 64'h0);
            guard++;
        end
        issue(0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, 64'h0);
        issue(0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, 64'h0);
        checks++;
        if (exp_q.size() != 0 || mq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results and %0d requests outstanding, required 0", exp_q.size(), mq.size());
        end
        // Reset asserted in the middle of an access
        rst_test = 1'b1;
        @(negedge clk);
        valid_E = 1; memRead_E = 1; memWrite_E = 0; aluResult_E = 64'h300;
        @(negedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (dm_req !== 1'b1 || stall_M !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: dm_req=%b stall_M=%b, required 1 1", dm_req, stall_M);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({dm_req, stall_M, valid_M, exc_M} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async: req=%b stall=%b valid=%b exc=%b, required 0 0 0 0", dm_req, stall_M, valid_M, exc_M);
        end
        @(negedge clk);
        valid_E = 0; memRead_E = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({dm_req, stall_M, valid_M, exc_M, excCode_M} !== 6'b0) begin
            errors++;
            $display("FAIL rst_after: req=%b stall=%b valid=%b exc=%b code=%b, required all 0",
                     dm_req, stall_M, valid_M, exc_M, excCode_M);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
